mips_multicycle_core: RTL and testbench
=======================================

Name: mips_multicycle_core

Overview:
- Next-generation MIPS core for the class processor family; replaces the single-cycle datapath with a multi-cycle FSM.
- Shares one ALU and one adder path across states.
- Adds load/store, jumps and memory-mapped I/O.
- Fetches instructions over a ready-handshaked external ROM port and holds an internal word-addressed data RAM.

Parameters:
- DATA_DEPTH, 64, data RAM depth in 32-bit words (power of 2).
- RESET_PC, 32'h0040_0000, PC value after reset.
- DATA_BASE, 32'h1001_0000, byte address of data RAM word 0.
- PORTOUT_ADDR, 32'h1001_0024, store to this address updates PortOut.
- PORTIN_ADDR, 32'h1001_0028, load from this address returns zero-extended PortIn.
- PORT_IN_WIDTH, 8, width of PortIn.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- PortIn  in  PORT_IN_WIDTH  external input port
- imem_rdata  in  32  instruction word from program ROM
- imem_ready  in  1  imem_rdata valid for imem_addr this cycle
- imem_req  out  1  fetch request
- imem_addr  out  32  byte address of fetch (= PC)
- PortOut  out  32  memory-mapped output register
- ALUResultOut  out  32  registered ALU result of last EXECUTE
- state_out  out  3  current FSM state encoding (for bench)
- retire  out  1  one-cycle pulse in the final state of each instruction
- illegal_op  out  1  one-cycle pulse when an unsupported opcode/funct retires

Behaviour:
- Reset (reset=0, asynchronous):
  - PC=RESET_PC; state=FETCH; IR, A, B, ALUOut, MDR, PortOut, ALUResultOut = 0.
  - All 32 GPRs = 0. Data RAM contents are not reset.
  - retire=0, illegal_op=0, imem_req=0 while in reset.
- Instruction set:
  - R-type: add, sub, and, or, nor, slt, sll, srl, jr.
  - I-type: addi, andi, ori, lui, slti, lw, sw, beq, bne.
  - J-type: j, jal.
  - Anything else is illegal.
- States (encoding 0..4): FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK.
- FETCH:
  - imem_req=1, imem_addr=PC.
  - Stays in FETCH while imem_ready=0, with PC/IR unchanged.
  - On the edge with imem_ready=1: IR<=imem_rdata, PC<=PC+4, go to DECODE.
- DECODE:
  - A<=GPR[rs], B<=GPR[rt].
  - ALUOut<=PC+(signext(imm)<<2) as branch target.
  - j/jal: PC<={PC[31:28],target,2'b00}; jal writes GPR31<=PC (already PC+4). Retire, go to FETCH.
  - Illegal: illegal_op and retire pulse, go to FETCH, no state change.
  - Otherwise go to EXECUTE.
- EXECUTE:
  - beq/bne: compare A-B; if taken, PC<=ALUOut. Retire, go to FETCH (3 cycles).
  - jr: PC<=A. Retire, go to FETCH.
  - Shifts use shamt (IR[10:6]) on B.
  - andi/ori zero-extend imm; addi/slti/lw/sw sign-extend; lui gives {imm,16'h0}.
  - Result goes to ALUOut and ALUResultOut.
  - lw/sw go to MEMORY; all other instructions go to WRITEBACK.
- MEMORY:
  - sw: address==PORTOUT_ADDR stores B to PortOut. Otherwise RAM[(addr-DATA_BASE)>>2 mod DATA_DEPTH]<=B. Retire, go to FETCH (4 cycles).
  - lw: MDR<=PortIn zero-extended if address==PORTIN_ADDR, else the RAM word. Go to WRITEBACK.
  - addr[1:0] are ignored (word access only).
- WRITEBACK:
  - R-type writes rd; I-type and lw write rt.
  - Retire, go to FETCH. R/I = 4 cycles excluding fetch wait; lw = 5.
- Register file:
  - Writes to GPR0 are discarded; GPR0 always reads 0.
  - Reads in DECODE see writes from the previous instruction.
- Arithmetic: 32-bit, overflow ignored (no traps); PC+4 wraps mod 2^32.
- Reset mid-instruction aborts immediately. A pending fetch is dropped; imem_ready seen after reset release applies only to the new FETCH.

Test Plan:
- Reset, ROM at 0x0040_0000: addi $t0,$zero,5; addi $t1,$zero,-3; add $t2,$t0,$t1. Required: 3 retire pulses, ALUResultOut=2, each instruction 4 cycles after fetch.
- imem_ready held low 3 cycles on second fetch. Required: state_out stays FETCH, PC holds 0x0040_0004, IR is latched only on the ready edge.
- sw $t0,0($gp) with $gp=0x1001_0000, then lw $t3,0($gp). Required: $t3=5, lw retires after 5 post-fetch cycles. Also sw to 0x1001_0024 sets PortOut=5.
- PortIn=8'hA5, lw from 0x1001_0028. Required: destination reg=0x0000_00A5.
- beq $t0,$t0,-1. Required: PC loops to same address, 3 cycles per iteration. bne with equal operands falls through to PC+4.
- jal at 0x0040_0010 then jr $ra. Required: $ra=0x0040_0014 and execution returns there. Opcode 6'h3F: illegal_op pulse, no reg change. addi $zero,$zero,7: $zero reads 0. Reset asserted during MEMORY: PortOut=0 and PC=RESET_PC.

Source files
------------

// File: rtl/mips_multicycle_core.sv
// rtl/mips_multicycle_core.sv - multi-cycle MIPS core with ROM fetch port, data RAM and memory-mapped I/O
// One shared ALU is sequenced through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
module mips_multicycle_core #(
  parameter int          DATA_DEPTH    = 64,
  parameter logic [31:0] RESET_PC      = 32'h0040_0000,
  parameter logic [31:0] DATA_BASE     = 32'h1001_0000,
  parameter logic [31:0] PORTOUT_ADDR  = 32'h1001_0024,
  parameter logic [31:0] PORTIN_ADDR   = 32'h1001_0028,
  parameter int          PORT_IN_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PORT_IN_WIDTH-1:0] PortIn,
  input  logic [31:0]              imem_rdata,
  input  logic                     imem_ready,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  output logic [31:0]              PortOut,
  output logic [31:0]              ALUResultOut,
  output logic [2:0]               state_out,
  output logic                     retire,
  output logic                     illegal_op
);
  localparam int AW = $clog2(DATA_DEPTH);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4
  } state_t;

  state_t      r_state, w_next;
  logic [31:0] r_pc, r_ir, r_a, r_b, r_aluout, r_mdr, r_port_out, r_alu_result;
  logic [31:0] r_gpr [32];
  logic [31:0] r_ram [DATA_DEPTH];

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt, w_wb_idx;
  logic [15:0] w_imm;
  logic [31:0] w_sext, w_zext, w_alu, w_wb_data, w_port_in_ext;
  logic        w_rtype, w_r_alu, w_jr, w_i_alu, w_lw, w_sw, w_beq, w_bne, w_j, w_jal, w_legal;
  logic        w_taken, w_is_portout, w_is_portin;
  logic [AW-1:0] w_ram_idx;

  assign w_op    = r_ir[31:26];
  assign w_rs    = r_ir[25:21];
  assign w_rt    = r_ir[20:16];
  assign w_rd    = r_ir[15:11];
  assign w_shamt = r_ir[10:6];
  assign w_funct = r_ir[5:0];
  assign w_imm   = r_ir[15:0];
  assign w_sext  = {{16{w_imm[15]}}, w_imm};
  assign w_zext  = {16'h0000, w_imm};

  assign w_rtype = (w_op == 6'h00);
  assign w_r_alu = w_rtype && (w_funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02});
  assign w_jr    = w_rtype && (w_funct == 6'h08);
  assign w_i_alu = w_op inside {6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h0A};
  assign w_lw    = (w_op == 6'h23);
  assign w_sw    = (w_op == 6'h2B);
  assign w_beq   = (w_op == 6'h04);
  assign w_bne   = (w_op == 6'h05);
  assign w_j     = (w_op == 6'h02);
  assign w_jal   = (w_op == 6'h03);
  assign w_legal = w_r_alu | w_jr | w_i_alu | w_lw | w_sw | w_beq | w_bne | w_j | w_jal;

  always_comb begin
    w_alu = r_a + w_sext;
    if (w_rtype) begin
      case (w_funct)
        6'h20:   w_alu = r_a + r_b;
        6'h22:   w_alu = r_a - r_b;
        6'h24:   w_alu = r_a & r_b;
        6'h25:   w_alu = r_a | r_b;
        6'h27:   w_alu = ~(r_a | r_b);
        6'h2A:   w_alu = {31'd0, $signed(r_a) < $signed(r_b)};
        6'h00:   w_alu = r_b << w_shamt;
        6'h02:   w_alu = r_b >> w_shamt;
        default: w_alu = r_a;
      endcase
    end else begin
      case (w_op)
        6'h0C:        w_alu = r_a & w_zext;
        6'h0D:        w_alu = r_a | w_zext;
        6'h0F:        w_alu = {w_imm, 16'h0000};
        6'h0A:        w_alu = {31'd0, $signed(r_a) < $signed(w_sext)};
        6'h04, 6'h05: w_alu = r_a - r_b;
        default:      w_alu = r_a + w_sext;
      endcase
    end
  end

  // Branch condition reuses the ALU subtraction rather than a separate comparator.
  assign w_taken       = (w_beq && (w_alu == 32'd0)) || (w_bne && (w_alu != 32'd0));
  assign w_is_portout  = (r_aluout[31:2] == PORTOUT_ADDR[31:2]);
  assign w_is_portin   = (r_aluout[31:2] == PORTIN_ADDR[31:2]);
  assign w_ram_idx     = AW'((r_aluout - DATA_BASE) >> 2);
  assign w_port_in_ext = {{(32 - PORT_IN_WIDTH){1'b0}}, PortIn};
  assign w_wb_idx      = w_rtype ? w_rd : w_rt;
  assign w_wb_data     = w_lw ? r_mdr : r_aluout;

  always_comb begin
    w_next     = r_state;
    retire     = 1'b0;
    illegal_op = 1'b0;
    case (r_state)
      S_FETCH:  if (imem_ready) w_next = S_DECODE;
      S_DECODE: begin
        if (w_j || w_jal) begin
          retire = 1'b1;
          w_next = S_FETCH;
        end else if (!w_legal) begin
          retire     = 1'b1;
          illegal_op = 1'b1;
          w_next     = S_FETCH;
        end else begin
          w_next = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (w_beq || w_bne || w_jr) begin
          retire = 1'b1;
          w_next = S_FETCH;
        end else if (w_lw || w_sw) begin
          w_next = S_MEMORY;
        end else begin
          w_next = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        if (w_sw) begin
          retire = 1'b1;
          w_next = S_FETCH;
        end else begin
          w_next = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        retire = 1'b1;
        w_next = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc         <= RESET_PC;
      r_ir         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_aluout     <= '0;
      r_mdr        <= '0;
      r_port_out   <= '0;
      r_alu_result <= '0;
      for (int i = 0; i < 32; i++) r_gpr[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ready) begin
            r_ir <= imem_rdata;
            r_pc <= r_pc + 32'd4;
          end
        end
        S_DECODE: begin
          r_a      <= r_gpr[w_rs];
          r_b      <= r_gpr[w_rt];
          r_aluout <= r_pc + {w_sext[29:0], 2'b00};
          if (w_j || w_jal) r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
          if (w_jal) r_gpr[31] <= r_pc;
        end
        S_EXECUTE: begin
          r_aluout     <= w_alu;
          r_alu_result <= w_alu;
          if (w_taken) r_pc <= r_aluout;
          if (w_jr)    r_pc <= r_a;
        end
        S_MEMORY: begin
          if (w_sw && w_is_portout) r_port_out <= r_b;
          if (w_lw) r_mdr <= w_is_portin ? w_port_in_ext : r_ram[w_ram_idx];
        end
        S_WRITEBACK: begin
          if (w_wb_idx != 5'd0) r_gpr[w_wb_idx] <= w_wb_data;
        end
        default: ;
      endcase
    end
  end

  // Data RAM is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (reset && (r_state == S_MEMORY) && w_sw && !w_is_portout) r_ram[w_ram_idx] <= r_b;
  end

  assign imem_req     = (r_state == S_FETCH) && reset;
  assign imem_addr    = r_pc;
  assign PortOut      = r_port_out;
  assign ALUResultOut = r_alu_result;
  assign state_out    = r_state;
endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb/tb_mips_multicycle_core.sv - scoreboard bench with an ISA-level reference model
module tb_mips_multicycle_core;
  localparam logic [31:0] RESET_PC     = 32'h0040_0000;
  localparam logic [31:0] DATA_BASE    = 32'h1001_0000;
  localparam logic [31:0] PORTOUT_ADDR = 32'h1001_0024;
  localparam logic [31:0] PORTIN_ADDR  = 32'h1001_0028;

  logic        clk, reset;
  logic [7:0]  PortIn;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        imem_req;
  logic [31:0] imem_addr, PortOut, ALUResultOut;
  logic [2:0]  state_out;
  logic        retire, illegal_op;

  mips_multicycle_core #(
    .DATA_DEPTH(64), .RESET_PC(RESET_PC), .DATA_BASE(DATA_BASE),
    .PORTOUT_ADDR(PORTOUT_ADDR), .PORTIN_ADDR(PORTIN_ADDR), .PORT_IN_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset), .PortIn(PortIn), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .imem_req(imem_req), .imem_addr(imem_addr),
    .PortOut(PortOut), .ALUResultOut(ALUResultOut), .state_out(state_out),
    .retire(retire), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          illegal;
    int          cycles;
    bit          alu_known;
    logic [31:0] alu;
    int          fetch_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] m_gpr [32];
  logic [31:0] m_ram [64];
  bit          m_written [64];
  logic [31:0] m_pc, m_port_out, m_alu;
  bit          m_alu_known;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
    m_pc        = RESET_PC;
    m_port_out  = 32'd0;
    m_alu       = 32'd0;
    m_alu_known = 1'b1;
  endtask

  // Architectural interpreter: one call per fetched instruction.
  task automatic model_exec(input logic [31:0] ins, input logic [7:0] pin, output exp_t e);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh;
    logic [31:0] a, b, sx, zx, pc4, nxt, val, addr;
    int          dst, idx;
    bit          alu;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    sh = ins[10:6];  fn = ins[5:0];
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'h0000, ins[15:0]};
    a = m_gpr[rs]; b = m_gpr[rt];
    pc4 = m_pc + 32'd4; nxt = pc4; val = 32'd0; dst = 0; alu = 1'b0;
    e.illegal = 1'b0; e.cycles = 4; e.fetch_cyc = 0;
    addr = a + sx;
    idx  = int'(((addr - DATA_BASE) >> 2) % 32'd64);
    case (op)
      6'h00: begin
        dst = rd; alu = 1'b1;
        case (fn)
          6'h20: val = a + b;
          6'h22: val = a - b;
          6'h24: val = a & b;
          6'h25: val = a | b;
          6'h27: val = ~(a | b);
          6'h2A: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h00: val = b << sh;
          6'h02: val = b >> sh;
          6'h08: begin nxt = a; e.cycles = 3; dst = 0; alu = 1'b0; m_alu_known = 1'b0; end
          default: begin e.illegal = 1'b1; e.cycles = 2; dst = 0; alu = 1'b0; end
        endcase
      end
      6'h08: begin val = a + sx; dst = rt; alu = 1'b1; end
      6'h0C: begin val = a & zx; dst = rt; alu = 1'b1; end
      6'h0D: begin val = a | zx; dst = rt; alu = 1'b1; end
      6'h0F: begin val = {ins[15:0], 16'h0000}; dst = rt; alu = 1'b1; end
      6'h0A: begin val = ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0; dst = rt; alu = 1'b1; end
      6'h23: begin
        e.cycles = 5; m_alu = addr; m_alu_known = 1'b1; dst = rt;
        val = ((addr & ~32'd3) == PORTIN_ADDR) ? {24'd0, pin} : m_ram[idx];
      end
      6'h2B: begin
        m_alu = addr; m_alu_known = 1'b1;
        if ((addr & ~32'd3) == PORTOUT_ADDR) m_port_out = b;
        else begin m_ram[idx] = b; m_written[idx] = 1'b1; end
      end
      6'h04: begin e.cycles = 3; m_alu_known = 1'b0; if (a == b) nxt = pc4 + (sx << 2); end
      6'h05: begin e.cycles = 3; m_alu_known = 1'b0; if (a != b) nxt = pc4 + (sx << 2); end
      6'h02: begin e.cycles = 2; nxt = {pc4[31:28], ins[25:0], 2'b00}; end
      6'h03: begin e.cycles = 2; nxt = {pc4[31:28], ins[25:0], 2'b00}; m_gpr[31] = pc4; end
      default: begin e.illegal = 1'b1; e.cycles = 2; end
    endcase
    if (alu) begin m_alu = val; m_alu_known = 1'b1; end
    if (dst != 0) m_gpr[dst] = val;
    m_pc = nxt;
    e.alu = m_alu;
    e.alu_known = m_alu_known;
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic int pick_word();
    int w = int'($urandom_range(0, 15));
    if (w == 9 || w == 10) w = w + 4;
    return w;
  endfunction

  function automatic logic [15:0] mem_off(input int w);
    return 16'(w * 4 + ($urandom_range(0, 1) != 0 ? 256 : 0) + int'($urandom_range(0, 3)));
  endfunction

  function automatic logic [31:0] gen_rand();
    int k, rs, rt, w, o;
    logic [5:0] fn, op;
    k  = int'($urandom_range(0, 99));
    rs = int'($urandom_range(0, 12));
    rt = int'($urandom_range(0, 12));
    if (k < 30) begin
      case ($urandom_range(0, 7))
        0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24; 3: fn = 6'h25;
        4: fn = 6'h27; 5: fn = 6'h2A; 6: fn = 6'h00; default: fn = 6'h02;
      endcase
      return enc_r(rs, rt, int'($urandom_range(0, 12)), int'($urandom_range(0, 31)), fn);
    end else if (k < 55) begin
      case ($urandom_range(0, 4))
        0: op = 6'h08; 1: op = 6'h0C; 2: op = 6'h0D; 3: op = 6'h0F; default: op = 6'h0A;
      endcase
      return enc_i(op, rs, rt, 16'($urandom));
    end else if (k < 65) begin
      if ($urandom_range(0, 3) == 0) return enc_i(6'h2B, 28, rt, 16'(36 + int'($urandom_range(0, 3))));
      return enc_i(6'h2B, 28, rt, mem_off(pick_word()));
    end else if (k < 75) begin
      for (int t = 0; t < 6; t++) begin
        w = pick_word();
        if (m_written[w]) return enc_i(6'h23, 28, rt, mem_off(w));
      end
      return enc_i(6'h23, 28, rt, 16'(40 + int'($urandom_range(0, 3))));
    end else if (k < 83) begin
      o = int'($urandom_range(0, 6)) - 3;
      if ($urandom_range(0, 1) != 0) rt = rs;
      return enc_i(($urandom_range(0, 1) != 0) ? 6'h04 : 6'h05, rs, rt, 16'(o));
    end else if (k < 88) begin
      return {($urandom_range(0, 1) != 0) ? 6'h02 : 6'h03, 26'($urandom)};
    end else if (k < 92) begin
      return enc_r(($urandom_range(0, 1) != 0) ? 31 : rs, 0, 0, 0, 6'h08);
    end
    case ($urandom_range(0, 3))
      0: return {6'h3F, 26'($urandom)};
      1: return enc_i(6'h09, rs, rt, 16'($urandom));
      2: return enc_r(rs, rt, 5, 0, 6'h21);
      default: return enc_r(rs, rt, 5, 1, 6'h03);
    endcase
  endfunction

  task automatic wait_fetch();
    int n = 0;
    @(negedge clk);
    while (!(state_out == 3'd0 && imem_req === 1'b1)) begin
      n++;
      if (n > 40) begin
        checks++; errors++;
        $display("FAIL fetch_timeout actual=state%0d required=FETCH", state_out);
        finish_run();
      end
      @(negedge clk);
    end
  endtask

  task automatic issue(input logic [31:0] ins, input int stall, input logic [7:0] pin);
    exp_t e;
    wait_fetch();
    for (int i = 0; i < stall; i++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
      check32("stall_state", 32'(state_out), 32'd0);
      check32("stall_pc", imem_addr, m_pc);
    end
    check32("fetch_pc", imem_addr, m_pc);
    check32("port_out", PortOut, m_port_out);
    PortIn = pin;
    model_exec(ins, pin, e);
    imem_rdata = ins;
    imem_ready = 1'b1;
    @(posedge clk);
    #1;
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    e.fetch_cyc = cyc;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (retire === 1'b1) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_retire actual=1 required=0");
        end else begin
          mon_e = sb.pop_front();
          check32("illegal_op", 32'(illegal_op), 32'(mon_e.illegal));
          check32("latency", 32'(cyc - mon_e.fetch_cyc + 2), 32'(mon_e.cycles));
          if (mon_e.alu_known) check32("alu_result", ALUResultOut, mon_e.alu);
        end
      end else begin
        check32("illegal_idle", 32'(illegal_op), 32'd0);
      end
    end
  end

  task automatic prologue();
    issue(enc_i(6'h0F, 0, 28, 16'h1001), 0, 8'($urandom));
  endtask

  initial begin
    int n;
    reset = 1'b0; imem_ready = 1'b0; imem_rdata = 32'd0; PortIn = 8'd0;
    for (int i = 0; i < 64; i++) m_written[i] = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check32("rst_state", 32'(state_out), 32'd0);
    check32("rst_pc", imem_addr, RESET_PC);
    check32("rst_portout", PortOut, 32'd0);
    check32("rst_alu", ALUResultOut, 32'd0);
    check32("rst_req", 32'(imem_req), 32'd0);
    check32("rst_retire", 32'(retire), 32'd0);
    reset = 1'b1;

    prologue();
    issue(enc_i(6'h08, 0, 8, 16'd5), 3, 8'd0);
    issue(enc_i(6'h08, 0, 9, 16'hFFFD), 0, 8'd0);
    issue(enc_r(8, 9, 10, 0, 6'h20), 0, 8'd0);
    issue(enc_i(6'h2B, 28, 8, 16'h0000), 0, 8'd0);
    issue(enc_i(6'h23, 28, 11, 16'h0000), 0, 8'd0);
    issue(enc_r(11, 0, 12, 0, 6'h20), 0, 8'd0);
    issue(enc_i(6'h2B, 28, 8, 16'h0024), 0, 8'd0);
    issue(enc_i(6'h23, 28, 13, 16'h0028), 1, 8'hA5);
    issue(enc_r(13, 0, 14, 0, 6'h20), 0, 8'd0);
    for (int i = 0; i < 3; i++) issue(enc_i(6'h04, 8, 8, 16'hFFFF), 0, 8'd0);
    issue(enc_i(6'h05, 8, 8, 16'hFFFF), 0, 8'd0);
    issue({6'h02, 26'h010_0004}, 0, 8'd0);
    issue({6'h03, 26'h010_0040}, 0, 8'd0);
    issue(enc_r(31, 0, 0, 0, 6'h08), 0, 8'd0);
    issue(enc_r(31, 0, 15, 0, 6'h20), 0, 8'd0);
    issue(32'hFC00_0000, 0, 8'd0);
    issue(enc_i(6'h08, 0, 0, 16'd7), 0, 8'd0);
    issue(enc_r(0, 0, 1, 0, 6'h20), 0, 8'd0);

    for (int i = 0; i < 250; i++) issue(gen_rand(), int'($urandom_range(0, 2)), 8'($urandom));

    issue(enc_i(6'h08, 0, 8, 16'd9), 0, 8'd0);
    issue(enc_i(6'h2B, 28, 8, 16'h0024), 0, 8'd0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (state_out != 3'd2 && n < 10);
    check32("reach_execute", 32'(state_out), 32'd2);
    @(posedge clk);
    #1;
    check32("in_memory", 32'(state_out), 32'd3);
    reset = 1'b0;
    #1;
    check32("abort_state", 32'(state_out), 32'd0);
    check32("abort_pc", imem_addr, RESET_PC);
    check32("abort_portout", PortOut, 32'd0);
    check32("abort_req", 32'(imem_req), 32'd0);
    check32("abort_retire", 32'(retire), 32'd0);
    sb.delete();
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    prologue();
    for (int i = 0; i < 60; i++) issue(gen_rand(), int'($urandom_range(0, 2)), 8'($urandom));

    n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check32("drain", 32'(sb.size()), 32'd0);
    finish_run();
  end
endmodule
